mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Shares one downstream channel between two valid/ready requesters by driving
//  the 2:1 data-mux select. Round-robin with bounded bursts: a granted requester
//  keeps the channel for up to MAX_BURST consecutive beats, then yields if the
//  other requester is waiting. One registered output stage decouples downstream
//  backpressure. Sits between producer pairs and a single shared consumer.
// PARAMETERS
//  WIDTH      8   data width of each requester and of the output
//  MAX_BURST  4   beats per grant before a forced yield; legal range >= 1
//                 (1 = strict alternation when both requesters are valid)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  req_valid  in   2      bit i: requester i presents a beat
//  req_data0  in   WIDTH  requester 0 data
//  req_data1  in   WIDTH  requester 1 data
//  req_ready  out  2      bit i: beat from requester i accepted this cycle
//  out_valid  out  1      registered output beat valid
//  out_data   out  WIDTH  registered output data
//  out_ready  in   1      downstream accepts out_data
//  grant      out  2      one-hot current owner; 2'b00 in IDLE
//  sel        out  1      mux select: 1 iff state == G1
// BEHAVIOUR
//  - States: IDLE, G0, G1 (registered). Burst counter cnt, width
//    $clog2(MAX_BURST+1). Pointer last: the most recently served requester.
//  - Reset (async, immediate): state=IDLE, cnt=0, last=1 (req 0 wins first
//    tie), out_valid=0, out_data=0. grant=0, sel=0, req_ready=0. A held
//    beat is discarded.
//  - free = !out_valid | out_ready. req_ready[i] = (state==Gi) & free.
//    Accept_i = req_valid[i] & req_ready[i]. A requester must hold valid and
//    data stable until accepted.
//  - Output stage: on accept, out_data <= selected data (via sel) and
//    out_valid <= 1. Else if out_ready, out_valid <= 0. Latency: accept edge
//    to out_valid = 1 cycle. Full throughput: one beat per cycle while free.
//  - FSM updates only when free; while stalled (out_valid & !out_ready), the
//    state, cnt and last are frozen.
//  - IDLE: exactly one valid -> that Gi. Both valid -> G(!last). None ->
//    stay. The IDLE cycle itself accepts nothing (1-cycle grant latency).
//  - Gi, accept: last<=i. If cnt+1==MAX_BURST and req_valid[j] -> Gj, cnt=0.
//    If cnt+1==MAX_BURST and !req_valid[j] -> stay, cnt=0 (burst renews).
//    Otherwise cnt<=cnt+1.
//  - Gi, !req_valid[i]: req_valid[j] -> Gj, else IDLE; cnt=0.
//  - grant never changes while out_valid & !out_ready, and never changes
//    in a cycle without an evaluation.
//  - Invariants: grant one-hot or zero. req_ready is never 2'b11. No beat is
//    duplicated or dropped except by reset.
// STRUCTURE
//  - Shared package mux_arb_pkg: state encodings (IDLE=2'd0, G0=2'd1,
//    G1=2'd2) and the cnt-width function. No other shared items.
//  - Sub-module: data steering is WIDTH instances of the existing 1-bit 2:1
//    mux cell (D[1:0], sel, y), generated per bit. Its sel is driven from
//    this block's sel. The FSM, counter and output register are inline.
// TESTING
//  1. Reset while out_valid=1 with data 8'hA5: all outputs read 0 and state
//     is IDLE at once, before any clock edge. Beat 8'hA5 never appears.
//  2. Only req0 valid, 6 beats 8'h01..8'h06, out_ready=1: grant=01 after 1
//     idle cycle. All 6 beats emerge in order, one per cycle. cnt renews at 4.
//  3. Both valid continuously, MAX_BURST=4, out_ready=1: output is 4 beats
//     from req0, then 4 from req1, repeating, with no idle cycle on a switch.
//  4. MAX_BURST=1, both valid: output strictly alternates 0,1,0,1. sel
//     toggles every cycle.
//  5. out_ready=0 for 5 cycles mid-burst: out_data held stable and
//     req_ready=00. State and cnt frozen. The burst resumes with the correct
//     remaining count after release.
//  6. req0 drops valid after 2 beats while req1 valid: grant moves to 10
//     the next cycle. If neither is valid, the FSM enters IDLE and grant=00.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester round-robin arbiter.
// Holds the FSM state encoding and the width rule for the burst counter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux2.sv
// 1-bit 2:1 mux cell: y = d[sel].
// Purely combinational, no latency, no flow control.
module mux_rr_arbiter_mux2 (
  input  logic [1:0] d,
  input  logic       sel,
  output logic       y
);

  assign y = sel ? d[1] : d[0];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered output between two valid/ready requesters.
// Latency: 1 cycle accept-to-out_valid, 1 idle cycle to grant from IDLE.
// Backpressure: while out_valid & !out_ready, req_ready=0 and the FSM is frozen.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             sel
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             free;
  logic             accept;
  logic             own_vld;
  logic             other_vld;
  logic [WIDTH-1:0] mux_y;

  assign free      = !out_valid_q || out_ready;
  assign sel       = (state_q == G1);
  assign grant     = {state_q == G1, state_q == G0};
  assign req_ready = grant & {2{free}};
  assign accept    = |(req_valid & req_ready);
  assign own_vld   = req_valid[sel];
  assign other_vld = req_valid[~sel];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    mux_rr_arbiter_mux2 u_mux (
      .d   ({req_data1[b], req_data0[b]}),
      .sel (sel),
      .y   (mux_y[b])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (free) begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          // Tie goes to whoever was not served most recently.
          if (req_valid == 2'b11)  state_d = last_q ? G0 : G1;
          else if (req_valid[0])   state_d = G0;
          else if (req_valid[1])   state_d = G1;
        end
        G0, G1: begin
          if (own_vld) begin
            last_d = sel;
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              if (other_vld) state_d = sel ? G0 : G1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = other_vld ? (sel ? G0 : G1) : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: queue-driven producers feed two arbiters (MAX_BURST 4 and 1);
// hand-computed output order is queued and a monitor checks every consumed beat.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [7:0] rdat [4];
  logic [1:0] rdy_a, rdy_b, grant_a, grant_b;
  logic       ov_a, ov_b, ordy_a, ordy_b, sel_a, sel_b;
  logic [7:0] od_a, od_b;

  logic [7:0] pq [4][$];
  logic [7:0] eq [2][$];
  int         checks, fails, cyc;
  int         pops [2];
  int         last_pop [2];

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(vld[1:0]), .req_data0(rdat[0]), .req_data1(rdat[1]),
    .req_ready(rdy_a), .out_valid(ov_a), .out_data(od_a), .out_ready(ordy_a),
    .grant(grant_a), .sel(sel_a)
  );

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld[3:2]), .req_data0(rdat[2]), .req_data1(rdat[3]),
    .req_ready(rdy_b), .out_valid(ov_b), .out_data(od_b), .out_ready(ordy_b),
    .grant(grant_b), .sel(sel_b)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic score(input int d, input logic [7:0] act);
    pops[d]++;
    last_pop[d] = cyc;
    if (eq[d].size() == 0) begin
      checks++;
      fails++;
      $display("FAIL beat_dut%0d: got unexpected beat %0h expected none", d, act);
    end else begin
      chk($sformatf("beat_dut%0d", d), act, eq[d].pop_front());
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      vld[k]  = (pq[k].size() != 0);
      rdat[k] = vld[k] ? pq[k][0] : 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int d);
    logic done;
    logic ov;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      ov = (d == 0) ? ov_a : ov_b;
      done = (eq[d].size() == 0) && (pq[2*d].size() == 0) && (pq[2*d+1].size() == 0) && !ov;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL drain_dut%0d: got %0d beats outstanding expected 0", d, eq[d].size());
    end
    step();
  endtask

  initial begin
    logic [3:0] acc;
    int         base, first;
    logic       seen;
    rst = 1'b1;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    checks = 0;
    fails = 0;
    cyc = 0;
    pops[0] = 0; pops[1] = 0;
    last_pop[0] = 0; last_pop[1] = 0;
    refresh();

    fork
      forever begin
        @(negedge clk);
        acc = vld & {rdy_b, rdy_a};
        @(posedge clk);
        cyc++;
        #2;
        for (int k = 0; k < 4; k++) if (acc[k]) void'(pq[k].pop_front());
        refresh();
      end
      forever begin
        @(negedge clk);
        if (ov_a && ordy_a) score(0, od_a);
        if (ov_b && ordy_b) score(1, od_b);
      end
    join_none

    // Reset values, then async reset with a held beat 8'hA5.
    #1;
    chk("rst_out_valid", ov_a, 0);
    chk("rst_grant", grant_a, 0);
    chk("rst_req_ready", rdy_a, 0);
    step(); step();
    rst = 1'b0;
    ordy_a = 1'b0;
    pq[0].push_back(8'hA5);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = ov_a;
    end
    chk("t1_held_valid", ov_a, 1);
    chk("t1_held_data", od_a, 8'hA5);
    step();
    #2 rst = 1'b1;
    #1;
    chk("t1_async_out_valid", ov_a, 0);
    chk("t1_async_out_data", od_a, 0);
    chk("t1_async_grant", grant_a, 0);
    chk("t1_async_sel", sel_a, 0);
    chk("t1_async_req_ready", rdy_a, 0);
    chk("t1_async_state", dut_a.state_q, IDLE);
    step();
    rst = 1'b0;
    ordy_a = 1'b1;
    step(); step();

    // Single requester, 6 beats; burst renews after 4.
    for (int i = 1; i <= 6; i++) begin
      pq[0].push_back(8'(i));
      eq[0].push_back(8'(i));
    end
    @(negedge clk); chk("t2_idle_grant", grant_a, 2'b00);
    @(negedge clk); chk("t2_grant", grant_a, 2'b01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("t2_cnt3", dut_a.cnt_q, 3);
    @(negedge clk); chk("t2_cnt_renew", dut_a.cnt_q, 0);
    chk("t2_grant_kept", grant_a, 2'b01);
    wait_drain(0);

    // Both valid, bursts of 4; last served was req0 so req1 goes first.
    base = pops[0];
    for (int i = 0; i < 8; i++) begin
      pq[0].push_back(8'h10 + 8'(i));
      pq[1].push_back(8'h20 + 8'(i));
    end
    for (int i = 0; i < 4; i++) eq[0].push_back(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) eq[0].push_back(8'h10 + 8'(i));
    for (int i = 4; i < 8; i++) eq[0].push_back(8'h20 + 8'(i));
    for (int i = 4; i < 8; i++) eq[0].push_back(8'h10 + 8'(i));
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = (pops[0] > base);
    end
    first = last_pop[0];
    wait_drain(0);
    chk("t3_beat_count", pops[0] - base, 16);
    chk("t3_no_gap_span", last_pop[0] - first, 15);

    // Stall mid-burst: cnt and state frozen, burst finishes its remaining 2 beats.
    for (int i = 0; i < 6; i++) pq[0].push_back(8'h30 + 8'(i));
    eq[0].push_back(8'h30); eq[0].push_back(8'h31); eq[0].push_back(8'h32);
    eq[0].push_back(8'h33); eq[0].push_back(8'h40); eq[0].push_back(8'h41);
    eq[0].push_back(8'h34); eq[0].push_back(8'h35);
    step(); step(); step();
    ordy_a = 1'b0;
    pq[1].push_back(8'h40);
    pq[1].push_back(8'h41);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t5_hold_data", od_a, 8'h31);
      chk("t5_hold_rdy", rdy_a, 2'b00);
      chk("t5_hold_state", dut_a.state_q, G0);
      chk("t5_hold_cnt", dut_a.cnt_q, 2);
    end
    step();
    ordy_a = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("t5_resume_cnt", dut_a.cnt_q, 3);
    @(negedge clk); chk("t5_yield_grant", grant_a, 2'b10);
    chk("t5_yield_cnt", dut_a.cnt_q, 0);
    wait_drain(0);

    // req0 drops after 2 beats while req1 waits; then both idle.
    pq[0].push_back(8'h50); pq[0].push_back(8'h51);
    eq[0].push_back(8'h50); eq[0].push_back(8'h51);
    eq[0].push_back(8'h60); eq[0].push_back(8'h61); eq[0].push_back(8'h62);
    step();
    pq[1].push_back(8'h60); pq[1].push_back(8'h61); pq[1].push_back(8'h62);
    @(negedge clk); chk("t6_grant_g0", grant_a, 2'b01);
    @(negedge clk);
    @(negedge clk); chk("t6_grant_before", grant_a, 2'b01);
    @(negedge clk); chk("t6_grant_moved", grant_a, 2'b10);
    repeat (4) @(negedge clk);
    chk("t6_idle_grant", grant_a, 2'b00);
    chk("t6_idle_state", dut_a.state_q, IDLE);
    wait_drain(0);

    // MAX_BURST=1: strict alternation, sel toggles each cycle.
    for (int i = 0; i < 4; i++) begin
      pq[2].push_back(8'h70 + 8'(i));
      pq[3].push_back(8'h80 + 8'(i));
      eq[1].push_back(8'h70 + 8'(i));
      eq[1].push_back(8'h80 + 8'(i));
    end
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("t4_sel_%0d", i), sel_b, (i % 2 == 0) ? 1 : 0);
    end
    wait_drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
